// File: rtl/fsqrt_arbiter_if.sv
// Requester, response and fsqrt-datapath signals of the fsqrt arbiter.
// slave = arbiter view, master = requesters plus the fsqrt unit.
interface fsqrt_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    resp_valid;
  logic [32*N_REQ-1:0] resp_data;
  logic [N_REQ-1:0]    resp_ready;
  logic [31:0]         sq_input_a;
  logic                sq_input_valid;
  logic [31:0]         sq_result;
  logic                sq_out_valid;
  logic                err;

  modport slave (
    input  req_valid, req_data, resp_ready, sq_result, sq_out_valid,
    output req_ready, resp_valid, resp_data, sq_input_a, sq_input_valid, err
  );

  modport master (
    output req_valid, req_data, resp_ready, sq_result, sq_out_valid,
    input  req_ready, resp_valid, resp_data, sq_input_a, sq_input_valid, err
  );
endinterface

// File: rtl/fsqrt_arbiter.sv
// Round-robin sharing of a non-stallable fsqrt unit; results reach the requester FIFO LAT+1 cycles after accept.
// Backpressure is by credit only: a requester is granted only while its FIFO plus in-flight ops leave room.
module fsqrt_arbiter #(
  parameter int N_REQ = 2,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  fsqrt_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [IW-1:0] id_t;

  logic [CW-1:0] fifo_count [N_REQ];
  logic [CW-1:0] inflight   [N_REQ];
  logic [PW-1:0] wptr       [N_REQ];
  logic [PW-1:0] rptr       [N_REQ];
  logic [31:0]   mem        [N_REQ][DEPTH];
  id_t           last_grant;
  logic [LAT-1:0] tag_vld;
  id_t           tag_id [LAT];
  logic          err_q;

  logic [N_REQ-1:0]    elig, grant, push_v, pop_v, dec_v, resp_vld;
  logic [32*N_REQ-1:0] resp_dat;
  logic                xfer;
  id_t                 grant_id, idx;
  logic                tail_vld, tail_full, err_set;
  id_t                 tail_id;

  // Credits come from registered counters only, so a pop frees a slot one cycle later.
  always_comb begin
    elig     = '0;
    grant    = '0;
    grant_id = '0;
    xfer     = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = bus.req_valid[i] &&
                (({1'b0, fifo_count[i]} + {1'b0, inflight[i]}) < DEPTH_W);
    for (int k = 1; k <= N_REQ; k++) begin
      idx = id_t'((int'(last_grant) + k) % N_REQ);
      if (!xfer && elig[idx]) begin
        xfer       = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  assign bus.req_ready      = rst_n ? grant : '0;
  assign bus.sq_input_valid = rst_n && xfer;
  assign bus.sq_input_a     = (rst_n && xfer) ? bus.req_data[32*grant_id +: 32] : 32'h0;

  assign tail_vld  = tag_vld[LAT-1];
  assign tail_id   = tag_id[LAT-1];
  assign tail_full = (fifo_count[tail_id] == CW'(DEPTH));
  assign err_set   = (bus.sq_out_valid != tail_vld) ||
                     (bus.sq_out_valid && tail_vld && tail_full);

  always_comb begin
    push_v   = '0;
    pop_v    = '0;
    dec_v    = '0;
    resp_vld = '0;
    resp_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      dec_v[i]    = tail_vld && (tail_id == id_t'(i));
      push_v[i]   = dec_v[i] && bus.sq_out_valid && !tail_full;
      resp_vld[i] = (fifo_count[i] != '0);
      pop_v[i]    = resp_vld[i] && bus.resp_ready[i];
      resp_dat[32*i +: 32] = resp_vld[i] ? mem[i][rptr[i]] : 32'h0;
    end
  end

  assign bus.resp_valid = resp_vld;
  assign bus.resp_data  = resp_dat;
  assign bus.err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
      last_grant <= id_t'(N_REQ - 1);
      err_q      <= 1'b0;
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= grant_id;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (xfer) last_grant <= grant_id;
      if (err_set) err_q <= 1'b1;
    end
  end

  // An orphan tag still retires its in-flight slot so the requester's credit is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        fifo_count[i] <= '0;
        inflight[i]   <= '0;
        wptr[i]       <= '0;
        rptr[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push_v[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop_v[i])  rptr[i] <= rptr[i] + 1'b1;
        case ({push_v[i], pop_v[i]})
          2'b10:   fifo_count[i] <= fifo_count[i] + 1'b1;
          2'b01:   fifo_count[i] <= fifo_count[i] - 1'b1;
          default: ;
        endcase
        case ({grant[i], dec_v[i]})
          2'b10:   inflight[i] <= inflight[i] + 1'b1;
          2'b01:   inflight[i] <= inflight[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      if (push_v[i]) mem[i][wptr[i]] <= bus.sq_result;
  end
endmodule
